ufi_master_write_arbiter: RTL

Sits directly upstream of the UFI slave allocation stage and merges write traffic from several UFI masters onto one registered UFI write bus (data, address, write enable). Arbitration is round-robin. A granted master keeps the bus until its burst ends or the beat limit is reached. It also rejects beats whose slave-select nibble, address bits [pUfiAdrsWidth-1 -: 4], is out of range, so the downstream stage never sees an unroutable write.

---
 rtl/ufi_master_write_arbiter_pkg.sv | 20 ++
 rtl/ufi_master_write_arbiter_rr_picker.sv | 43 ++++
 rtl/ufi_master_write_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/ufi_master_write_arbiter_pkg.sv
// ufi_master_write_arbiter_pkg
// Shared UFI constants, state encoding and slice helpers.
package ufi_master_write_arbiter_pkg;

    localparam int cUfiSelWidth = 4;

    localparam logic [0:0] cStIdle  = 1'b0;
    localparam logic [0:0] cStBurst = 1'b1;

    // Low bit of master idx's slice in a packed per-master bus
    function automatic int fnSliceLo(input int idx, input int width);
        return idx * width;
    endfunction

    // Low bit of the slave-select nibble in an address
    function automatic int fnSelLo(input int adrsWidth);
        return adrsWidth - cUfiSelWidth;
    endfunction

endpackage

// File: rtl/ufi_master_write_arbiter_rr_picker.sv
// ufi_rr_picker
// Combinational round-robin search from a pointer, with wrap.
module ufi_rr_picker #(
    parameter int pReqNum = 4,
    parameter int pIdxW   = $clog2(pReqNum)
) (
    input  logic [pReqNum-1:0] iReq,
    input  logic [pIdxW-1:0]   iPtr,
    output logic [pReqNum-1:0] oGrant,
    output logic [pIdxW-1:0]   oIdx,
    output logic               oValid
);

    localparam logic [pIdxW:0] cNum = pReqNum[pIdxW:0];

    logic [2*pReqNum-1:0] reqDbl;
    logic [pReqNum-1:0]   reqRot;
    logic [pIdxW:0]       sum;

    assign reqDbl = {iReq, iReq} >> iPtr;
    assign reqRot = reqDbl[pReqNum-1:0];

    // First requester at or after the pointer wins
    always_comb begin
        oValid = 1'b0;
        sum    = '0;
        for (int k = pReqNum - 1; k >= 0; k--) begin
            if (reqRot[k]) begin
                oValid = 1'b1;
                sum    = {1'b0, iPtr} + k[pIdxW:0];
            end
        end
        if (sum >= cNum) begin
            sum = sum - cNum;
        end
        oIdx   = sum[pIdxW-1:0];
        oGrant = '0;
        if (oValid) begin
            oGrant[oIdx] = 1'b1;
        end
    end

endmodule

// File: rtl/ufi_master_write_arbiter.sv
// ufi_master_write_arbiter
// Round-robin merge of UFI master writes onto one registered bus.
module ufi_master_write_arbiter
    import ufi_master_write_arbiter_pkg::*;
#(
    parameter int pUfiBusWidth      = 32,
    parameter int pUfiAdrsWidth     = 32,
    parameter int pUfiMasterNum     = 4,
    parameter int pUfiAllocationNum = 9,
    parameter int pBurstMax         = 16
) (
    input  logic                                   iCLK,
    input  logic                                   iRST,
    input  logic [pUfiMasterNum*pUfiBusWidth-1:0]  iMUfiWd,
    input  logic [pUfiMasterNum*pUfiAdrsWidth-1:0] iMUfiWAdrs,
    input  logic [pUfiMasterNum-1:0]               iMUfiWReq,
    input  logic [pUfiMasterNum-1:0]               iMUfiWLast,
    output logic [pUfiMasterNum-1:0]               oMUfiWRdy,
    output logic [pUfiBusWidth-1:0]                oSUfiWd,
    output logic [pUfiAdrsWidth-1:0]               oSUfiWAdrs,
    output logic                                   oSUfiWEd,
    output logic                                   oAdrsErr,
    output logic [$clog2(pUfiMasterNum)-1:0]       oGrantId
);

    localparam int cIdW    = $clog2(pUfiMasterNum);
    localparam int cCntW   = $clog2(pBurstMax) + 1;
    localparam int cSelLo  = fnSelLo(pUfiAdrsWidth);
    localparam int cLastI  = pUfiMasterNum - 1;
    localparam int cBurstI = pBurstMax - 1;

    localparam logic [cUfiSelWidth:0] cAllocLim =
        pUfiAllocationNum[cUfiSelWidth:0];
    localparam logic [cIdW-1:0]  cLastId    = cLastI[cIdW-1:0];
    localparam logic [cCntW-1:0] cBurstLast = cBurstI[cCntW-1:0];

    logic [0:0]               state;
    logic [cIdW-1:0]          rrPtr;
    logic [cIdW-1:0]          grantIdx;
    logic [pUfiMasterNum-1:0] grantVec;
    logic [cCntW-1:0]         beatCnt;

    logic [pUfiBusWidth-1:0]  mWd   [pUfiMasterNum];
    logic [pUfiAdrsWidth-1:0] mAdrs [pUfiMasterNum];

    logic [pUfiMasterNum-1:0] pickVec;
    logic [cIdW-1:0]          pickIdx;
    logic                     pickValid;

    logic [pUfiBusWidth-1:0]  curWd;
    logic [pUfiAdrsWidth-1:0] curAdrs;
    logic                     accept;
    logic                     selLegal;
    logic                     burstEnd;
    logic [cIdW-1:0]          ptrNext;

    for (genvar g = 0; g < pUfiMasterNum; g++) begin : gSlice
        assign mWd[g] =
            iMUfiWd[fnSliceLo(g, pUfiBusWidth) +: pUfiBusWidth];
        assign mAdrs[g] =
            iMUfiWAdrs[fnSliceLo(g, pUfiAdrsWidth) +: pUfiAdrsWidth];
    end

    ufi_rr_picker #(
        .pReqNum (pUfiMasterNum)
    ) uPicker (
        .iReq   (iMUfiWReq),
        .iPtr   (rrPtr),
        .oGrant (pickVec),
        .oIdx   (pickIdx),
        .oValid (pickValid)
    );

    assign curWd    = mWd[grantIdx];
    assign curAdrs  = mAdrs[grantIdx];
    assign accept   = (state == cStBurst) && iMUfiWReq[grantIdx];
    assign selLegal =
        {1'b0, curAdrs[cSelLo +: cUfiSelWidth]} < cAllocLim;
    assign burstEnd = accept &&
        (iMUfiWLast[grantIdx] || (beatCnt == cBurstLast));
    assign ptrNext  =
        (grantIdx == cLastId) ? '0 : grantIdx + cIdW'(1);

    assign oMUfiWRdy = (state == cStBurst) ? grantVec : '0;
    assign oGrantId  = grantIdx;

    // Arbitrate in IDLE, count beats and release in BURST
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state    <= cStIdle;
            rrPtr    <= '0;
            grantIdx <= '0;
            grantVec <= '0;
            beatCnt  <= '0;
        end else if (state == cStIdle) begin
            if (pickValid) begin
                state    <= cStBurst;
                grantIdx <= pickIdx;
                grantVec <= pickVec;
                beatCnt  <= '0;
            end
        end else if (accept) begin
            beatCnt <= beatCnt + 1'b1;
            if (burstEnd) begin
                state <= cStIdle;
                rrPtr <= ptrNext;
            end
        end
    end

    // Register accepted beats; illegal selects pulse the error flag
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            oSUfiWd    <= '0;
            oSUfiWAdrs <= '0;
            oSUfiWEd   <= 1'b0;
            oAdrsErr   <= 1'b0;
        end else begin
            oSUfiWEd <= accept && selLegal;
            oAdrsErr <= accept && !selLegal;
            if (accept) begin
                oSUfiWd    <= curWd;
                oSUfiWAdrs <= curAdrs;
            end
        end
    end

endmodule
